serial_subtractor: RTL and testbench

Bit-serial subtractor: captures two WIDTH-bit operands on `start` and produces `in1 - in2` LSB-first, one bit per clock, using a single registered borrow. It is the subtracting counterpart of the team's combinational half-adder datapath. It trades latency for area in low-rate arithmetic paths of the FPGA design.

---
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor. Operands are captured on an accepted start and the
//   result in1 - in2 is formed LSB-first, one bit per clock, with a single
//   registered borrow. Arithmetic wraps modulo 2^WIDTH.
//
//   Optional feature macro: SERIAL_ADD_EN adds an 'op' input (1 = add,
//   0 = subtract), captured with the operands; bout then reports carry out.
//
// Ports
//   sys_clk  in   clock, rising edge
//   sys_rst  in   asynchronous reset, active-high
//   start    in   operation request, sampled only in IDLE
//   in1      in   [WIDTH] minuend
//   in2      in   [WIDTH] subtrahend
//   op       in   add/subtract select (SERIAL_ADD_EN builds only)
//   busy     out  high in SHIFT and DONE
//   done     out  one-cycle pulse, diff/bout valid
//   diff     out  [WIDTH] result, held until the next result lands
//   bout     out  borrow out (carry out in add mode)
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
`ifdef SERIAL_ADD_EN
   input  logic             op,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef SERIAL_ADD_EN
   logic             op_q, op_d;
`endif

   logic d_bit;
   logic br_nx;
   logic [WIDTH-1:0] res_nx;

   always_comb begin
      d_bit = a_q[0] ^ b_q[0] ^ br_q;
`ifdef SERIAL_ADD_EN
      if (op_q)
         br_nx = (a_q[0] & b_q[0]) | (br_q & (a_q[0] ^ b_q[0]));
      else
         br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
`else
      br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
`endif
      // result fills from the MSB; after WIDTH shifts bit 0 is the first d
      res_nx = {d_bit, res_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
`ifdef SERIAL_ADD_EN
      op_d    = op_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = in1;
               b_d     = in2;
               br_d    = 1'b0;
               cnt_d   = '0;
               res_d   = '0;
`ifdef SERIAL_ADD_EN
               op_d    = op;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_nx;
            res_d = res_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // outputs are registered so they land together with done
               diff_d  = res_nx;
               bout_d  = br_nx;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADD_EN
         op_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADD_EN
         op_q    <= op_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor at WIDTH=8. Inputs are
//   driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic         start   = 1'b0;
   logic [W-1:0] in1     = '0;
   logic [W-1:0] in2     = '0;
`ifdef SERIAL_ADD_EN
   logic         op      = 1'b0;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .start   (start),
      .in1     (in1),
      .in2     (in2),
`ifdef SERIAL_ADD_EN
      .op      (op),
`endif
      .busy    (busy),
      .done    (done),
      .diff    (diff),
      .bout    (bout)
   );

   always #5 sys_clk = ~sys_clk;

   // Pulse start for one cycle, then wait (bounded) for done. lat counts
   // edges from the accepting edge inclusive; -1 on timeout.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c,
                         output int lat);
      @(negedge sys_clk);
      start = 1'b1; in1 = x; in2 = y;
      @(negedge sys_clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 30) begin
         @(negedge sys_clk);
         lat++;
      end
      if (!done) lat = -1;
      r = diff;
      c = bout;
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, diff, bout} !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b, want all 0",
                  busy, done, diff, bout);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] r; logic c; int lat;
      run_op(8'd5, 8'd3, r, c, lat);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
      checks++;
      if ({c, r} !== {1'b0, 8'd2}) begin
         errors++; $display("FAIL basic_result: got bout=%b diff=%h want 0/02", c, r);
      end
      @(negedge sys_clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, done);
      end
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({bout, diff} !== {1'b0, 8'd2}) begin
         errors++; $display("FAIL basic_hold: got bout=%b diff=%h want 0/02", bout, diff);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] r; logic c; int lat;
      run_op(8'd3, 8'd5, r, c, lat);
      checks++;
      if (lat !== 9 || {c, r} !== {1'b1, 8'hFE}) begin
         errors++; $display("FAIL wrap_3m5: lat=%0d bout=%b diff=%h want 9 1/fe", lat, c, r);
      end
      run_op(8'd0, 8'd0, r, c, lat);
      checks++;
      if (lat !== 9 || {c, r} !== {1'b0, 8'h00}) begin
         errors++; $display("FAIL zero_0m0: lat=%0d bout=%b diff=%h want 9 0/00", lat, c, r);
      end
   endtask

   task automatic test_ignore_start();
      int n; int dones;
      @(negedge sys_clk);
      start = 1'b1; in1 = 8'd9; in2 = 8'd4;
      @(negedge sys_clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 30) begin
         if (n == 3) begin start = 1'b1; in1 = 8'hFF; in2 = 8'h01; end
         else start = 1'b0;
         @(negedge sys_clk);
         n++;
      end
      start = 1'b0;
      checks++;
      if (n !== 9 || {bout, diff} !== {1'b0, 8'd5}) begin
         errors++; $display("FAIL ignore_first: lat=%0d bout=%b diff=%h want 9 0/05", n, bout, diff);
      end
      dones = 0;
      repeat (15) begin
         @(negedge sys_clk);
         if (done) dones++;
      end
      checks++;
      if (dones !== 0 || diff !== 8'd5) begin
         errors++; $display("FAIL ignore_no_second: extra dones=%0d diff=%h want 0 05", dones, diff);
      end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] r; logic c; int lat; int dones;
      @(negedge sys_clk);
      start = 1'b1; in1 = 8'd200; in2 = 8'd1;
      @(negedge sys_clk);
      start = 1'b0;
      repeat (4) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, diff, bout} !== '0) begin
         errors++; $display("FAIL abort_clear: busy=%b done=%b diff=%h bout=%b want all 0",
                            busy, done, diff, bout);
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      dones = 0;
      repeat (12) begin
         @(negedge sys_clk);
         if (done || busy) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++; $display("FAIL abort_no_done: active cycles=%0d want 0", dones);
      end
      run_op(8'd10, 8'd4, r, c, lat);
      checks++;
      if (lat !== 9 || {c, r} !== {1'b0, 8'd6}) begin
         errors++; $display("FAIL abort_restart: lat=%0d bout=%b diff=%h want 9 0/06", lat, c, r);
      end
   endtask

`ifdef SERIAL_ADD_EN
   task automatic test_add();
      logic [W-1:0] r; logic c; int lat;
      op = 1'b1;
      run_op(8'hFF, 8'h01, r, c, lat);
      checks++;
      if (lat !== 9 || {c, r} !== {1'b1, 8'h00}) begin
         errors++; $display("FAIL add_ff_01: lat=%0d cout=%b diff=%h want 9 1/00", lat, c, r);
      end
      run_op(8'd100, 8'd27, r, c, lat);
      checks++;
      if ({c, r} !== {1'b0, 8'd127}) begin
         errors++; $display("FAIL add_100_27: cout=%b diff=%h want 0/7f", c, r);
      end
      op = 1'b0;
      run_op(8'd7, 8'd2, r, c, lat);
      checks++;
      if ({c, r} !== {1'b0, 8'd5}) begin
         errors++; $display("FAIL sub_mode_7m2: bout=%b diff=%h want 0/05", c, r);
      end
   endtask
`endif

   task automatic test_back_to_back();
      int first; int second; int n;
      // start held high relaunches every W+2 cycles
      @(negedge sys_clk);
      start = 1'b1; in1 = 8'd50; in2 = 8'd20;
      first = -1; second = -1; n = 0;
      while (second < 0 && n < 40) begin
         @(negedge sys_clk);
         n++;
         if (done) begin
            if (first < 0) first = n; else second = n;
         end
      end
      start = 1'b0;
      checks++;
      if (first !== 9 || second !== 19 || diff !== 8'd30) begin
         errors++; $display("FAIL back_to_back: dones at %0d,%0d diff=%h want 9,19 1e",
                            first, second, diff);
      end
      repeat (12) @(negedge sys_clk);
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, r; logic c; int lat; int bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         run_op(x, y, r, c, lat);
         checks++;
         if (lat !== 9 || {c, r} !== {(x < y), W'(x - y)}) begin
            errors++;
            if (bad < 10)
               $display("FAIL random_%0d: %h-%h lat=%0d got %b/%h want %b/%h",
                        i, x, y, lat, c, r, (x < y), W'(x - y));
            bad++;
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge sys_clk);
      test_reset();
      sys_rst = 1'b0;
      test_basic();
      test_wrap();
      test_ignore_start();
      test_reset_abort();
`ifdef SERIAL_ADD_EN
      test_add();
`endif
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
